// File: rtl/jk_excitation_driver.sv
// Steers an external JK flop through a target bit sequence (LSB first) using the JK excitation
// table, and checks the flop's q one cycle later against the bit it was steered toward.
module jk_excitation_driver #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8,
    parameter bit XVAL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNTW-1:0]  err_cnt,
    input  logic             err_clr
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [IDXW-1:0]  bit_idx;
    logic             exp_bit_p1;
    logic             exp_vld_p1;
    logic             accept;
    logic             last_bit;
    logic             cmp_en;
    logic             cmp_err;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    assign accept   = in_valid && (state == IDLE);
    assign last_bit = (bit_idx == IDXW'(WIDTH - 1));
    // The bit steered in cycle n lands in the flop at the end of n, so q_fb is checked in n+1.
    assign cmp_en   = ((state == DRIVE) && exp_vld_p1) || (state == FLUSH);
    assign cmp_err  = cmp_en && (q_fb != exp_bit_p1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = DRIVE;
            DRIVE:   if (last_bit) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == DRIVE) || (state == FLUSH);
        j        = 1'b0;
        k        = 1'b0;
        if (state == DRIVE) begin
            if (!q_fb) begin
                j = shreg[0];
                k = XVAL;
            end else begin
                j = XVAL;
                k = ~shreg[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bit_idx    <= '0;
            exp_bit_p1 <= 1'b0;
            exp_vld_p1 <= 1'b0;
        end else if (accept) begin
            shreg      <= in_data;
            bit_idx    <= '0;
            exp_vld_p1 <= 1'b0;
        end else if (state == DRIVE) begin
            shreg      <= shreg >> 1;
            bit_idx    <= bit_idx + IDXW'(1);
            exp_bit_p1 <= shreg[0];
            exp_vld_p1 <= 1'b1;
        end else begin
            exp_vld_p1 <= 1'b0;
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done     <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            done <= (state == FLUSH);
            if (err_clr) begin
                mismatch <= 1'b0;
                err_cnt  <= '0;
            end else if (cmp_err) begin
                mismatch <= 1'b1;
                err_cnt  <= sat_inc(err_cnt);
            end
        end
    end

endmodule
